// File: rtl/bus_demultiplexer_if.sv
// Purpose: valid/ready bundle between the result-bus source, the demux and its
//          two write ports (A and B).
// Signals:
//   in_valid/in_ready/in_dest/in_data : source-side handshake and payload
//   out_valid_a/out_ready_a           : port A handshake
//   out_valid_b/out_ready_b           : port B handshake
//   out_data                          : operand shared by both ports
//   discard_count                     : running count of dest=00 transfers
// Modports: master = source and sinks (the environment), slave = the demux.
interface bus_demultiplexer_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_dest;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid_a;
  logic               out_ready_a;
  logic               out_valid_b;
  logic               out_ready_b;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] discard_count;

  modport master (
    output in_valid, in_dest, in_data, out_ready_a, out_ready_b,
    input  in_ready, out_valid_a, out_valid_b, out_data, discard_count
  );

  modport slave (
    input  in_valid, in_dest, in_data, out_ready_a, out_ready_b,
    output in_ready, out_valid_a, out_valid_b, out_data, discard_count
  );
endinterface

// File: rtl/bus_demultiplexer.sv
// Purpose: routes one operand per valid/ready handshake to port A, port B,
//          both (broadcast) or nowhere (discard, counted), by a 2-bit code.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bus_demultiplexer_if.slave (source handshake, A/B handshakes,
//          shared out_data, discard_count)
// Every output is a flop; nothing on the output side depends combinationally
// on any input.
module bus_demultiplexer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  bus_demultiplexer_if.slave bus
);

  // Destination codes; pending uses the same bit layout (bit0 = A, bit1 = B).
  localparam logic [1:0] DEST_DISCARD = 2'b00;
  localparam logic [1:0] PEND_NONE    = 2'b00;

  logic [1:0]         pending_q, pending_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               accept;

  // State registers; in_ready is kept as its own flop mirroring pending==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= PEND_NONE;
      data_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      pending_q  <= pending_d;
      data_q     <= data_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state: per-port completion, then capture of a new transfer.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    count_d   = count_q;
    accept    = bus.in_valid & in_ready_q;

    if (pending_q[0] && bus.out_ready_a) pending_d[0] = 1'b0;
    if (pending_q[1] && bus.out_ready_b) pending_d[1] = 1'b0;

    // Accept only happens with pending empty, so it cannot collide with a
    // completion above.
    if (accept) begin
      if (bus.in_dest == DEST_DISCARD) begin
        count_d = count_q + COUNT_W'(1);
      end else begin
        pending_d = bus.in_dest;
        data_d    = bus.in_data;
      end
    end

    in_ready_d = (pending_d == PEND_NONE);
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid_a   = pending_q[0];
  assign bus.out_valid_b   = pending_q[1];
  assign bus.out_data      = data_q;
  assign bus.discard_count = count_q;

endmodule

// File: tb/tb_bus_demultiplexer.sv
module tb_bus_demultiplexer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned COUNT_W = 8;

  logic clk;
  logic rst;

  bus_demultiplexer_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

  bus_demultiplexer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: which ports are still owed the current operand, the operand
  // itself, and how many discards have been seen (modulo 2^COUNT_W).
  bit        owe_a, owe_b;
  int        ref_data;
  int        ref_discards;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    owe_a = 0; owe_b = 0; ref_data = 0; ref_discards = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(!(owe_a || owe_b)));
    chk({tag, ".valid_a"},  32'(bus.out_valid_a), 32'(owe_a));
    chk({tag, ".valid_b"},  32'(bus.out_valid_b), 32'(owe_b));
    chk({tag, ".data"},     32'(bus.out_data), 32'(ref_data));
    chk({tag, ".count"},    32'(bus.discard_count), 32'(ref_discards % (1 << COUNT_W)));
  endtask

  // One clock: apply the transfer rules to what the DUT saw at the edge,
  // then check all outputs 1 time unit later.
  task automatic cycle(input string tag);
    bit idle;
    @(posedge clk);
    if (rst) begin
      ref_reset();
    end else begin
      idle = !(owe_a || owe_b);
      if (owe_a && bus.out_ready_a) owe_a = 0;
      if (owe_b && bus.out_ready_b) owe_b = 0;
      if (bus.in_valid && idle) begin
        if (bus.in_dest == 2'd0) begin
          ref_discards = ref_discards + 1;
        end else begin
          owe_a    = bus.in_dest[0];
          owe_b    = bus.in_dest[1];
          ref_data = int'(bus.in_data);
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [1:0] d, input logic [7:0] x,
                       input bit ra, input bit rb);
    bus.in_valid    = v;
    bus.in_dest     = d;
    bus.in_data     = x;
    bus.out_ready_a = ra;
    bus.out_ready_b = rb;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'd0, 8'h00, 0, 0);
    ref_reset();
    repeat (2) cycle("init");
    #3 rst = 1'b0;

    // Test 1: reset mid-simulation after some activity.
    drive(1, 2'd0, 8'h00, 0, 0); cycle("t1.pre");
    drive(1, 2'd2, 8'h77, 0, 0); cycle("t1.pre");
    #3 rst = 1'b1; #1;
    ref_reset();
    check_all("t1.rst");
    #2 rst = 1'b0;
    drive(0, 2'd0, 8'h00, 0, 0);
    cycle("t1.idle");

    // Test 2: single transfer to port A.
    drive(1, 2'd1, 8'h5A, 1, 0); cycle("t2.cap");
    chk("t2.valid_a_high", 32'(bus.out_valid_a), 32'd1);
    chk("t2.data_5a", 32'(bus.out_data), 32'h5A);
    drive(0, 2'd0, 8'h00, 1, 0); cycle("t2.done");
    chk("t2.valid_a_low", 32'(bus.out_valid_a), 32'd0);
    cycle("t2.idle");

    // Test 3: broadcast, B stalls three cycles.
    drive(1, 2'd3, 8'hC3, 1, 0); cycle("t3.cap");
    drive(0, 2'd0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cycle("t3.stall");
    chk("t3.b_waiting", 32'(bus.out_valid_b), 32'd1);
    chk("t3.a_done", 32'(bus.out_valid_a), 32'd0);
    bus.out_ready_b = 1'b1; cycle("t3.b_done");
    chk("t3.ready_back", 32'(bus.in_ready), 32'd1);

    // Test 4: 257 back-to-back discards wrap the counter to 1.
    drive(1, 2'd0, 8'hFF, 1, 1);
    for (int i = 0; i < 257; i++) cycle("t4.disc");
    chk("t4.count_wrapped", 32'(bus.discard_count), 32'd1);

    // Test 5: B stalls five cycles while the next transfer waits on input.
    drive(1, 2'd2, 8'h11, 0, 0); cycle("t5.cap");
    drive(1, 2'd1, 8'h22, 0, 0);
    for (int i = 0; i < 5; i++) cycle("t5.hold");
    chk("t5.held_11", 32'(bus.out_data), 32'h11);
    bus.out_ready_b = 1'b1; cycle("t5.b_done");
    bus.out_ready_b = 1'b0; cycle("t5.cap22");
    chk("t5.data_22", 32'(bus.out_data), 32'h22);
    drive(0, 2'd0, 8'h00, 1, 0); cycle("t5.a_done");

    // Test 6: async reset while a broadcast is pending.
    drive(1, 2'd3, 8'h99, 0, 0); cycle("t6.cap");
    drive(0, 2'd0, 8'h00, 0, 0);
    #3 rst = 1'b1; #1;
    ref_reset();
    chk("t6.va_drop", 32'(bus.out_valid_a), 32'd0);
    chk("t6.vb_drop", 32'(bus.out_valid_b), 32'd0);
    chk("t6.ready", 32'(bus.in_ready), 32'd1);
    chk("t6.data", 32'(bus.out_data), 32'd0);
    #2 rst = 1'b0;
    drive(0, 2'd0, 8'h00, 1, 1);
    repeat (3) cycle("t6.after");

    // Randomized traffic; the model ignores source inputs while busy.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) != 0));
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
